decoder_phase_sequencer: RTL and testbench
==========================================

// Module: decoder_phase_sequencer
// PURPOSE
//  Stage directly upstream of the DECODER_I_* tree. It owns the opcode latch (ITABLE) and the
//  per-instruction phase counter (XPT), and drives both with their complements plus the decoder enable.
//  It consumes the decoder's end-of-instruction strobes (PR_Reset_XPT, P2_Reset_ITABLE, P2_Set_CM1,
//  Pa_Ophd) to close one instruction and fetch the next.
// PARAMETERS
//  XPT_W    4    phase counter width
//  OP_W     8    opcode width
//  MAX_XPT  15   last legal phase; an instruction that reaches it without ending is a fault
// PORTS
//  CLK               in   1      single clock, rising edge
//  notRESET          in   1      synchronous, active-low reset
//  DATA_IN           in   OP_W   opcode byte from the fetch bus
//  DATA_VALID        in   1      DATA_IN valid this cycle (fetch handshake)
//  STALL             in   1      hold the current phase (e.g. memory wait)
//  PR_Reset_XPT      in   1      end of instruction (from decoder)
//  P2_Reset_ITABLE   in   1      clear the opcode latch at end of instruction
//  P2_Set_CM1        in   1      set CM1 (first machine cycle) at end of instruction
//  Pa_Ophd           in   1      opcode-head advance request
//  FETCH_REQ         out  1      requesting an opcode byte
//  enable            out  1      decoder enable
//  XPT / notXPT      out  XPT_W  phase and its bitwise complement
//  ITABLE/notITABLE  out  OP_W   latched opcode and its bitwise complement
//  CM1               out  1      first machine cycle flag
//  OPHD_STROBE       out  1      one-cycle PC-advance pulse to the fetch unit
//  FAULT             out  1      phase overrun; sticky until reset
// BEHAVIOUR
//  - Reset (notRESET=0 at an edge): state=IDLE, XPT=0, notXPT=all 1s, ITABLE=0, notITABLE=all 1s,
//    CM1=1, enable=0, FETCH_REQ=0, OPHD_STROBE=0, FAULT=0. Reset dominates every other input.
//  - Complements: notXPT and notITABLE are registered alongside their true values. They always equal
//    the exact inverse; there is no cycle in which both are 0.
//  - States: IDLE -> FETCH -> EXEC -> FETCH ...; FAULT is terminal.
//  - IDLE: lasts one cycle after reset release, then moves to FETCH.
//  - FETCH: FETCH_REQ=1, enable=0, XPT held at 0.
//    On an edge with DATA_VALID=1: ITABLE<=DATA_IN, XPT<=0, CM1<=0, state->EXEC.
//    enable=1 from the next cycle, so the opcode reaches the decoder 1 cycle after the handshake.
//  - EXEC: enable = ~STALL (combinational).
//    STALL=1: XPT, ITABLE and state hold, and all decoder strobes are ignored.
//    STALL=0, PR_Reset_XPT=1: XPT<=0; ITABLE<=0 if P2_Reset_ITABLE; CM1<=1 if P2_Set_CM1;
//    state->FETCH.
//    STALL=0, PR_Reset_XPT=0: XPT<=XPT+1.
//  - P2_Reset_ITABLE and P2_Set_CM1 take effect only together with PR_Reset_XPT; alone they are ignored.
//  - OPHD_STROBE: registered. It is 1 in the cycle after any EXEC edge with enable=1 and Pa_Ophd=1.
//  - Overrun: in EXEC with XPT==MAX_XPT, STALL=0 and PR_Reset_XPT=0 -> state=FAULT, FAULT=1, enable=0,
//    FETCH_REQ=0, XPT holds MAX_XPT (no wrap to 0). Only reset leaves FAULT.
//  - PR_Reset_XPT at XPT==MAX_XPT is a legal end of instruction and does not fault.
//  - DATA_VALID outside FETCH is ignored; FETCH waits indefinitely for DATA_VALID.
// TESTING
//  - Reset: hold notRESET=0 for 2 cycles -> XPT=0, notXPT=4'hF, ITABLE=8'h00, notITABLE=8'hFF, CM1=1,
//    FAULT=0. FETCH_REQ=1 on the 2nd cycle after release.
//  - Fetch/step: DATA_IN=8'h19 with DATA_VALID -> next cycle ITABLE=8'h19, notITABLE=8'hE6, enable=1,
//    CM1=0. XPT then reads 0,1,2,3 on consecutive cycles.
//  - End of instruction: PR_Reset_XPT=P2_Reset_ITABLE=P2_Set_CM1=1 at XPT=3 -> next cycle XPT=0,
//    ITABLE=0, CM1=1, FETCH_REQ=1, enable=0.
//  - Stall: STALL=1 for 3 cycles at XPT=2 while PR_Reset_XPT=1 -> XPT stays 2, enable=0, no
//    transition. After STALL drops, the reset is taken.
//  - Overrun: never assert PR_Reset_XPT -> FAULT=1 the cycle after XPT=15, XPT stays 15. A later
//    DATA_VALID is ignored; only reset clears FAULT.
//  - Mid-op reset: notRESET=0 at XPT=5 in EXEC -> all outputs return to their reset values at the
//    next edge.

Source files
------------

// File: rtl/decoder_phase_sequencer.sv
// decoder_phase_sequencer: owns the opcode latch (ITABLE) and the per-instruction
// phase counter (XPT) that feed the decoder tree. It fetches an opcode, steps the
// phase until the decoder signals end of instruction, and then fetches again.
// A phase overrun parks the block in a sticky FAULT state until reset.
//
// Fetch handshake (valid/ready): a byte transfers on a rising edge where
// DATA_VALID=1 and FETCH_REQ=1. FETCH_REQ is the ready side and is high only in
// FETCH. DATA_VALID seen in any other state is ignored and nothing is latched.
module decoder_phase_sequencer #(
  parameter int XPT_W   = 4,
  parameter int OP_W    = 8,
  parameter int MAX_XPT = 15
) (
  input  logic             CLK,
  input  logic             notRESET,
  input  logic [OP_W-1:0]  DATA_IN,
  input  logic             DATA_VALID,
  input  logic             STALL,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Reset_ITABLE,
  input  logic             P2_Set_CM1,
  input  logic             Pa_Ophd,
  output logic             FETCH_REQ,
  output logic             enable,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [OP_W-1:0]  ITABLE,
  output logic [OP_W-1:0]  notITABLE,
  output logic             CM1,
  output logic             OPHD_STROBE,
  output logic             FAULT,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [XPT_W-1:0] LAST_PH = XPT_W'(MAX_XPT);

  state_t             state_q, state_d;
  logic [XPT_W-1:0]   xpt_q, xpt_d;
  logic [OP_W-1:0]    itable_q, itable_d;
  logic               cm1_q, cm1_d;
  logic               ophd_q, ophd_d;

  // Next-state and next-value logic; complements are derived from the same
  // next value so the true and inverted registers can never disagree.
  always_comb begin
    state_d   = state_q;
    xpt_d     = xpt_q;
    itable_d  = itable_q;
    cm1_d     = cm1_q;
    ophd_d    = 1'b0;
    FETCH_REQ = 1'b0;
    enable    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        FETCH_REQ = 1'b1;
        xpt_d     = '0;
        if (DATA_VALID) begin
          itable_d = DATA_IN;
          cm1_d    = 1'b0;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        enable = ~STALL;
        ophd_d = ~STALL & Pa_Ophd;
        if (!STALL) begin
          if (PR_Reset_XPT) begin
            // End of instruction; the P2 strobes only qualify this event.
            xpt_d   = '0;
            state_d = S_FETCH;
            if (P2_Reset_ITABLE) itable_d = '0;
            if (P2_Set_CM1)      cm1_d    = 1'b1;
          end else if (xpt_q == LAST_PH) begin
            // Overrun: hold the last phase rather than wrap to 0.
            state_d = S_FAULT;
          end else begin
            xpt_d = xpt_q + XPT_W'(1);
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!notRESET) begin
      state_q   <= S_IDLE;
      xpt_q     <= '0;
      notXPT    <= '1;
      itable_q  <= '0;
      notITABLE <= '1;
      cm1_q     <= 1'b1;
      ophd_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xpt_q     <= xpt_d;
      notXPT    <= ~xpt_d;
      itable_q  <= itable_d;
      notITABLE <= ~itable_d;
      cm1_q     <= cm1_d;
      ophd_q    <= ophd_d;
    end
  end

  assign XPT         = xpt_q;
  assign ITABLE      = itable_q;
  assign CM1         = cm1_q;
  assign OPHD_STROBE = ophd_q;
  assign FAULT       = (state_q == S_FAULT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_decoder_phase_sequencer.sv
// Directed bench for decoder_phase_sequencer: reset, fetch/step, end of
// instruction, stall, strobe qualification, overrun, legal end at the last
// phase and mid-instruction reset. Inputs change 1ns after a rising edge and
// outputs are checked there too, away from the active edge.
module tb_decoder_phase_sequencer;

  logic       CLK = 1'b0;
  logic       notRESET;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       STALL;
  logic       PR_Reset_XPT;
  logic       P2_Reset_ITABLE;
  logic       P2_Set_CM1;
  logic       Pa_Ophd;
  logic       FETCH_REQ;
  logic       enable;
  logic [3:0] XPT;
  logic [3:0] notXPT;
  logic [7:0] ITABLE;
  logic [7:0] notITABLE;
  logic       CM1;
  logic       OPHD_STROBE;
  logic       FAULT;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  decoder_phase_sequencer #(.XPT_W(4), .OP_W(8), .MAX_XPT(15)) dut (
    .CLK(CLK), .notRESET(notRESET), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .STALL(STALL), .PR_Reset_XPT(PR_Reset_XPT), .P2_Reset_ITABLE(P2_Reset_ITABLE),
    .P2_Set_CM1(P2_Set_CM1), .Pa_Ophd(Pa_Ophd), .FETCH_REQ(FETCH_REQ),
    .enable(enable), .XPT(XPT), .notXPT(notXPT), .ITABLE(ITABLE),
    .notITABLE(notITABLE), .CM1(CM1), .OPHD_STROBE(OPHD_STROBE), .FAULT(FAULT),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_strobes();
    DATA_VALID = 1'b0; STALL = 1'b0; PR_Reset_XPT = 1'b0;
    P2_Reset_ITABLE = 1'b0; P2_Set_CM1 = 1'b0; Pa_Ophd = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_xpt"},       32'(XPT), 32'h0);
    check({tag, "_notxpt"},    32'(notXPT), 32'hF);
    check({tag, "_itable"},    32'(ITABLE), 32'h00);
    check({tag, "_notitable"}, 32'(notITABLE), 32'hFF);
    check({tag, "_cm1"},       32'(CM1), 32'h1);
    check({tag, "_fault"},     32'(FAULT), 32'h0);
    check({tag, "_fetch_req"}, 32'(FETCH_REQ), 32'h0);
    check({tag, "_enable"},    32'(enable), 32'h0);
    check({tag, "_ophd"},      32'(OPHD_STROBE), 32'h0);
  endtask

  // Release reset and walk IDLE -> FETCH, then hand over one opcode.
  task automatic start_and_fetch(input logic [7:0] op);
    notRESET = 1'b1;
    step();
    DATA_IN = op; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
  endtask

  initial begin
    notRESET = 1'b0; DATA_IN = 8'h00;
    clear_strobes();

    // Reset held for 2 cycles
    step(); step();
    check_reset_values("rst");

    // Release: first cycle is IDLE, FETCH_REQ follows one cycle later
    notRESET = 1'b1;
    check("idle_fetch_req", 32'(FETCH_REQ), 32'h0);
    step();
    check("fetch_req_up", 32'(FETCH_REQ), 32'h1);
    check("fetch_enable", 32'(enable), 32'h0);
    // FETCH waits for DATA_VALID
    step(); step();
    check("fetch_wait_req", 32'(FETCH_REQ), 32'h1);
    check("fetch_wait_xpt", 32'(XPT), 32'h0);

    // Fetch 0x19
    DATA_IN = 8'h19; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check("op19_itable", 32'(ITABLE), 32'h19);
    check("op19_notitable", 32'(notITABLE), 32'hE6);
    check("op19_enable", 32'(enable), 32'h1);
    check("op19_cm1", 32'(CM1), 32'h0);
    check("op19_xpt0", 32'(XPT), 32'h0);
    check("op19_fetch_req", 32'(FETCH_REQ), 32'h0);

    // Pa_Ophd for one EXEC edge -> one-cycle strobe
    Pa_Ophd = 1'b1;
    step();
    Pa_Ophd = 1'b0;
    check("op19_xpt1", 32'(XPT), 32'h1);
    check("ophd_pulse", 32'(OPHD_STROBE), 32'h1);
    check("op19_notxpt1", 32'(notXPT), 32'hE);

    // P2 strobes without PR_Reset_XPT are ignored
    P2_Reset_ITABLE = 1'b1; P2_Set_CM1 = 1'b1;
    step();
    check("op19_xpt2", 32'(XPT), 32'h2);
    check("ophd_drop", 32'(OPHD_STROBE), 32'h0);
    step();
    check("op19_xpt3", 32'(XPT), 32'h3);
    check("p2_alone_itable", 32'(ITABLE), 32'h19);
    check("p2_alone_cm1", 32'(CM1), 32'h0);

    // End of instruction at XPT=3
    PR_Reset_XPT = 1'b1;
    step();
    clear_strobes();
    check("eoi_xpt", 32'(XPT), 32'h0);
    check("eoi_itable", 32'(ITABLE), 32'h00);
    check("eoi_notitable", 32'(notITABLE), 32'hFF);
    check("eoi_cm1", 32'(CM1), 32'h1);
    check("eoi_fetch_req", 32'(FETCH_REQ), 32'h1);
    check("eoi_enable", 32'(enable), 32'h0);

    // Second instruction 0xA5; DATA_VALID in EXEC is ignored
    DATA_IN = 8'hA5; DATA_VALID = 1'b1;
    step();
    check("opa5_itable", 32'(ITABLE), 32'hA5);
    check("opa5_notitable", 32'(notITABLE), 32'h5A);
    DATA_IN = 8'h3C;
    step();
    DATA_VALID = 1'b0;
    check("valid_in_exec_itable", 32'(ITABLE), 32'hA5);
    check("opa5_xpt1", 32'(XPT), 32'h1);
    step();
    check("opa5_xpt2", 32'(XPT), 32'h2);

    // Stall for 3 cycles at XPT=2 with end-of-instruction pending
    STALL = 1'b1; PR_Reset_XPT = 1'b1; Pa_Ophd = 1'b1;
    #1;
    check("stall_enable", 32'(enable), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_xpt", 32'(XPT), 32'h2);
      check("stall_notxpt", 32'(notXPT), 32'hD);
      check("stall_fetch_req", 32'(FETCH_REQ), 32'h0);
      check("stall_ophd", 32'(OPHD_STROBE), 32'h0);
    end
    STALL = 1'b0;
    #1;
    check("unstall_enable", 32'(enable), 32'h1);
    step();
    clear_strobes();
    check("unstall_eoi_xpt", 32'(XPT), 32'h0);
    check("unstall_eoi_fetch_req", 32'(FETCH_REQ), 32'h1);
    check("unstall_itable_kept", 32'(ITABLE), 32'hA5);
    check("unstall_cm1_kept", 32'(CM1), 32'h0);
    check("unstall_ophd", 32'(OPHD_STROBE), 32'h1);

    // Overrun: fetch 0x7E and never end the instruction
    DATA_IN = 8'h7E; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check("ovr_ophd_clear", 32'(OPHD_STROBE), 32'h0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("ovr_count", 32'(XPT), 32'(i));
    end
    check("ovr_no_fault_yet", 32'(FAULT), 32'h0);
    step();
    check("ovr_fault", 32'(FAULT), 32'h1);
    check("ovr_xpt_hold", 32'(XPT), 32'hF);
    check("ovr_notxpt", 32'(notXPT), 32'h0);
    check("ovr_enable", 32'(enable), 32'h0);
    check("ovr_fetch_req", 32'(FETCH_REQ), 32'h0);
    DATA_IN = 8'h11; DATA_VALID = 1'b1;
    step(); step();
    DATA_VALID = 1'b0;
    check("ovr_sticky", 32'(FAULT), 32'h1);
    check("ovr_itable_kept", 32'(ITABLE), 32'h7E);

    // Reset clears FAULT
    notRESET = 1'b0;
    step();
    check_reset_values("rst2");

    // PR_Reset_XPT at the last phase is a legal end
    start_and_fetch(8'h42);
    check("max_itable", 32'(ITABLE), 32'h42);
    for (int i = 0; i < 15; i++) step();
    check("max_xpt15", 32'(XPT), 32'hF);
    PR_Reset_XPT = 1'b1;
    step();
    clear_strobes();
    check("max_eoi_fault", 32'(FAULT), 32'h0);
    check("max_eoi_xpt", 32'(XPT), 32'h0);
    check("max_eoi_fetch_req", 32'(FETCH_REQ), 32'h1);

    // Mid-instruction reset at XPT=5
    DATA_IN = 8'h81; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_xpt5", 32'(XPT), 32'h5);
    notRESET = 1'b0; DATA_VALID = 1'b1; Pa_Ophd = 1'b1;
    step();
    clear_strobes();
    check_reset_values("mid_rst");

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
